// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute stage: opcodes, flag bit positions,
// FSM state encoding and the Z/N/C/V flag packing helper.
package alu_exec_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] ALU_OPX_ADD   = 4'd0;
  localparam logic [3:0] ALU_OPX_ADC   = 4'd1;
  localparam logic [3:0] ALU_OPX_SUB   = 4'd2;
  localparam logic [3:0] ALU_OPX_SBC   = 4'd3;
  localparam logic [3:0] ALU_OPX_AND   = 4'd4;
  localparam logic [3:0] ALU_OPX_OR    = 4'd5;
  localparam logic [3:0] ALU_OPX_XOR   = 4'd6;
  localparam logic [3:0] ALU_OPX_NOT   = 4'd7;
  localparam logic [3:0] ALU_OPX_MOV   = 4'd8;
  localparam logic [3:0] ALU_OPX_SHL   = 4'd9;
  localparam logic [3:0] ALU_OPX_SHR   = 4'd10;
  localparam logic [3:0] ALU_OPX_SRA   = 4'd11;
  localparam logic [3:0] ALU_OPX_MUL   = 4'd12;
  localparam logic [3:0] ALU_OPX_CMP   = 4'd13;
  localparam logic [3:0] ALU_OPX_RSV14 = 4'd14;
  localparam logic [3:0] ALU_OPX_RSV15 = 4'd15;

  localparam int ALU_FLAG_Z = 3;
  localparam int ALU_FLAG_N = 2;
  localparam int ALU_FLAG_C = 1;
  localparam int ALU_FLAG_V = 0;

  typedef enum logic {
    ALU_ST_IDLE = 1'b0,
    ALU_ST_RUN  = 1'b1
  } alu_state_t;

  function automatic logic [3:0] mk_flags(input logic [DATA_W-1:0] res,
                                          input logic c, input logic v);
    logic [3:0] f;
    f             = '0;
    f[ALU_FLAG_Z] = (res == '0);
    f[ALU_FLAG_N] = res[DATA_W-1];
    f[ALU_FLAG_C] = c;
    f[ALU_FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/opcode request and result/handshake bundle between the control
// sequencer (master) and the ALU execute stage (slave).
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic [DATA_W-1:0] ALUA_DATA;
  logic [DATA_W-1:0] ALUB_DATA;
  logic [3:0]        ALU_OPX;
  logic              ALU_START;
  logic [DATA_W-1:0] ALU_R;
  logic [3:0]        ALU_FLAGS;
  logic              ALU_BUSY;
  logic              ALU_DONE;

  modport master (
    output ALUA_DATA, ALUB_DATA, ALU_OPX, ALU_START,
    input  ALU_R, ALU_FLAGS, ALU_BUSY, ALU_DONE
  );

  modport slave (
    input  ALUA_DATA, ALUB_DATA, ALU_OPX, ALU_START,
    output ALU_R, ALU_FLAGS, ALU_BUSY, ALU_DONE
  );
endinterface

// File: rtl/alu_adder.sv
// 16-bit add/subtract with carry-in. When sub=1 it computes a-b-cin and
// reports borrow on carry; ovf is two's-complement overflow in both modes.
module alu_adder
  import alu_exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic              ovf
);
  logic [DATA_W-1:0] b_eff;
  logic              c_eff;
  logic              cout;

  always_comb begin
    b_eff       = sub ? ~b : b;
    c_eff       = sub ? ~cin : cin;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, c_eff};
    carry       = cout ^ sub;
    ovf         = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  end
endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle arithmetic/logic, bit-serial shifts and an
// optional shift-add multiplier (enabled by defining ALU_MUL_EN).
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  alu_exec_if.slave  bus
);
  alu_state_t        state, state_nxt;
  logic [DATA_W-1:0] r_q, r_nxt;
  logic [3:0]        flags_q, flags_nxt;
  logic              done_q, done_nxt;
  logic [4:0]        cnt_q, cnt_nxt;
  logic [DATA_W-1:0] acc_q, acc_nxt;
  logic [3:0]        op_q, op_nxt;
  logic [DATA_W-1:0] lres, shv;
  logic              sout;
  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_sub, add_carry, add_ovf;
`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] lo_q, lo_nxt, mcand_q, mcand_nxt;
  logic [DATA_W:0]   mul_sum;
`endif

  alu_adder u_adder (
    .a(add_a), .b(add_b), .cin(add_cin), .sub(add_sub),
    .sum(add_sum), .carry(add_carry), .ovf(add_ovf)
  );

  // Adder is shared: operands from the bus while idle, multiply accumulate while running
  always_comb begin
    add_a   = bus.ALUA_DATA;
    add_b   = bus.ALUB_DATA;
    add_cin = 1'b0;
    add_sub = 1'b0;
    if (state == ALU_ST_IDLE) begin
      add_sub = (bus.ALU_OPX == ALU_OPX_SUB) || (bus.ALU_OPX == ALU_OPX_SBC) ||
                (bus.ALU_OPX == ALU_OPX_CMP);
      if ((bus.ALU_OPX == ALU_OPX_ADC) || (bus.ALU_OPX == ALU_OPX_SBC))
        add_cin = flags_q[ALU_FLAG_C];
    end
`ifdef ALU_MUL_EN
    else begin
      add_a = acc_q;
      add_b = mcand_q;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r_q;
    flags_nxt = flags_q;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt_q;
    acc_nxt   = acc_q;
    op_nxt    = op_q;
    lres      = '0;
    shv       = acc_q;
    sout      = 1'b0;
`ifdef ALU_MUL_EN
    lo_nxt    = lo_q;
    mcand_nxt = mcand_q;
    mul_sum   = '0;
`endif
    case (state)
      ALU_ST_IDLE: begin
        if (bus.ALU_START) begin
          op_nxt  = bus.ALU_OPX;
          acc_nxt = bus.ALUA_DATA;
          case (bus.ALU_OPX)
            ALU_OPX_ADD, ALU_OPX_ADC, ALU_OPX_SUB, ALU_OPX_SBC: begin
              r_nxt     = add_sum;
              flags_nxt = mk_flags(add_sum, add_carry, add_ovf);
              done_nxt  = 1'b1;
            end
            ALU_OPX_CMP: begin
              flags_nxt = mk_flags(add_sum, add_carry, add_ovf);
              done_nxt  = 1'b1;
            end
            ALU_OPX_AND, ALU_OPX_OR, ALU_OPX_XOR, ALU_OPX_NOT, ALU_OPX_MOV: begin
              case (bus.ALU_OPX)
                ALU_OPX_AND: lres = bus.ALUA_DATA & bus.ALUB_DATA;
                ALU_OPX_OR:  lres = bus.ALUA_DATA | bus.ALUB_DATA;
                ALU_OPX_XOR: lres = bus.ALUA_DATA ^ bus.ALUB_DATA;
                ALU_OPX_NOT: lres = ~bus.ALUA_DATA;
                default:     lres = bus.ALUB_DATA;
              endcase
              r_nxt     = lres;
              flags_nxt = mk_flags(lres, 1'b0, 1'b0);
              done_nxt  = 1'b1;
            end
            ALU_OPX_SHL, ALU_OPX_SHR, ALU_OPX_SRA: begin
              if (bus.ALUB_DATA[3:0] == 4'd0) begin
                r_nxt     = bus.ALUA_DATA;
                flags_nxt = mk_flags(bus.ALUA_DATA, 1'b0, 1'b0);
                done_nxt  = 1'b1;
              end else begin
                cnt_nxt   = {1'b0, bus.ALUB_DATA[3:0]};
                state_nxt = ALU_ST_RUN;
              end
            end
`ifdef ALU_MUL_EN
            ALU_OPX_MUL: begin
              acc_nxt   = '0;
              lo_nxt    = bus.ALUB_DATA;
              mcand_nxt = bus.ALUA_DATA;
              cnt_nxt   = 5'd16;
              state_nxt = ALU_ST_RUN;
            end
`endif
            ALU_OPX_RSV14, ALU_OPX_RSV15: begin
              r_nxt    = bus.ALUA_DATA;
              done_nxt = 1'b1;
            end
            default: begin
              r_nxt    = bus.ALUA_DATA;
              done_nxt = 1'b1;
            end
          endcase
        end
      end
      ALU_ST_RUN: begin
        cnt_nxt = cnt_q - 5'd1;
        case (op_q)
          ALU_OPX_SHL: begin shv = {acc_q[DATA_W-2:0], 1'b0};       sout = acc_q[DATA_W-1]; end
          ALU_OPX_SHR: begin shv = {1'b0, acc_q[DATA_W-1:1]};       sout = acc_q[0];        end
          ALU_OPX_SRA: begin shv = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]}; sout = acc_q[0];   end
          default: ;
        endcase
        acc_nxt = shv;
`ifdef ALU_MUL_EN
        // {acc, lo} is the 32-bit partial product; conditionally add, then shift right
        if (op_q == ALU_OPX_MUL) begin
          mul_sum = lo_q[0] ? {add_carry, add_sum} : {1'b0, acc_q};
          acc_nxt = mul_sum[DATA_W:1];
          lo_nxt  = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
`endif
        if (cnt_q == 5'd1) begin
          state_nxt = ALU_ST_IDLE;
          done_nxt  = 1'b1;
`ifdef ALU_MUL_EN
          if (op_q == ALU_OPX_MUL) begin
            r_nxt     = lo_nxt;
            flags_nxt = mk_flags(lo_nxt, |acc_nxt, 1'b0);
          end else
`endif
          begin
            r_nxt     = shv;
            flags_nxt = mk_flags(shv, sout, 1'b0);
          end
        end
      end
      default: state_nxt = ALU_ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ALU_ST_IDLE;
      r_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      r_q     <= r_nxt;
      flags_q <= flags_nxt;
      done_q  <= done_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Working operands only matter while RUN, which reset already leaves
  always_ff @(posedge CLK) begin
    acc_q   <= acc_nxt;
    op_q    <= op_nxt;
`ifdef ALU_MUL_EN
    lo_q    <= lo_nxt;
    mcand_q <= mcand_nxt;
`endif
  end

  assign bus.ALU_R     = r_q;
  assign bus.ALU_FLAGS = flags_q;
  assign bus.ALU_BUSY  = (state == ALU_ST_RUN);
  assign bus.ALU_DONE  = done_q;
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expected result, flags
// and completion cycle; a negedge monitor pops and compares on every DONE.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  alu_exec_if bus ();

  alu_exec dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.ALU_DONE === 1'b1) begin
      if (q.size() == 0) begin
        check("stray_done", 32'(bus.ALU_DONE), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_r"},     32'(bus.ALU_R),     32'(mon_e.r));
        check({mon_e.name, "_flags"}, 32'(bus.ALU_FLAGS), 32'(mon_e.f));
        check({mon_e.name, "_cycle"}, 32'(cyc),           32'(mon_e.cyc));
        check({mon_e.name, "_busy"},  32'(bus.ALU_BUSY),  32'd0);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef,
                       input int off, input bit push = 1'b1);
    @(negedge CLK);
    bus.ALUA_DATA = a;
    bus.ALUB_DATA = b;
    bus.ALU_OPX   = op;
    bus.ALU_START = 1'b1;
    @(posedge CLK);
    #1;
    if (push) q.push_back('{r: er, f: ef, cyc: cyc + off, name: nm});
  endtask

  task automatic settle(input int off);
    bus.ALU_START = 1'b0;
    repeat (off) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET         = 1'b1;
    bus.ALUA_DATA = '0;
    bus.ALUB_DATA = '0;
    bus.ALU_OPX   = '0;
    bus.ALU_START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_r",     32'(bus.ALU_R),     32'd0);
    check("rst_flags", 32'(bus.ALU_FLAGS), 32'd0);
    check("rst_busy",  32'(bus.ALU_BUSY),  32'd0);
    check("rst_done",  32'(bus.ALU_DONE),  32'd0);
    RESET = 1'b0;

    issue("add", ALU_OPX_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0);
    check("add_busy", 32'(bus.ALU_BUSY), 32'd0);
    settle(0);
    issue("sub", ALU_OPX_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 0); settle(0);
    issue("cmp", ALU_OPX_CMP, 16'h0005, 16'h0005, 16'hFFFE, 4'b1000, 0); settle(0);

    // START stays high with an ADD while the shift is busy; it must be ignored
    issue("sra4", ALU_OPX_SRA, 16'h8001, 16'h0004, 16'hF800, 4'b0100, 4);
    bus.ALU_OPX   = ALU_OPX_ADD;
    bus.ALUA_DATA = 16'h0001;
    bus.ALUB_DATA = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      check("sra4_busy", 32'(bus.ALU_BUSY), 32'd1);
      if (i == 2) bus.ALU_START = 1'b0;
      @(posedge CLK);
      #1;
    end
    check("sra4_busy_end", 32'(bus.ALU_BUSY), 32'd0);

    issue("shl1",  ALU_OPX_SHL, 16'h8000, 16'h0001, 16'h0000, 4'b1010, 1);  settle(1);
    issue("shr0",  ALU_OPX_SHR, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 0);  settle(0);
    issue("sra15", ALU_OPX_SRA, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100, 15); settle(15);
    issue("shr15", ALU_OPX_SHR, 16'hC000, 16'h000F, 16'h0001, 4'b0010, 15); settle(15);
    issue("adc",   ALU_OPX_ADC, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 0);  settle(0);
    issue("sbc",   ALU_OPX_SBC, 16'h0005, 16'h0002, 16'h0002, 4'b0000, 0);  settle(0);
    issue("and",   ALU_OPX_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 0);  settle(0);
    issue("or",    ALU_OPX_OR,  16'h8000, 16'h0001, 16'h8001, 4'b0100, 0);  settle(0);
    issue("xor",   ALU_OPX_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 0);  settle(0);
    issue("not",   ALU_OPX_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 0);  settle(0);
    issue("mov",   ALU_OPX_MOV, 16'h0000, 16'h8000, 16'h8000, 4'b0100, 0);  settle(0);
    issue("rsv14", ALU_OPX_RSV14, 16'h0000, 16'h5555, 16'h0000, 4'b0100, 0); settle(0);
    issue("rsv15", ALU_OPX_RSV15, 16'hABCD, 16'h0000, 16'hABCD, 4'b0100, 0); settle(0);

`ifdef ALU_MUL_EN
    issue("mul1", ALU_OPX_MUL, 16'h0100, 16'h0101, 16'h0100, 4'b0010, 16);
    bus.ALU_START = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("mul1_busy", 32'(bus.ALU_BUSY), 32'd1);
      @(posedge CLK);
      #1;
    end
    check("mul1_busy_end", 32'(bus.ALU_BUSY), 32'd0);
    issue("mul2", ALU_OPX_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 16); settle(16);
    issue("mul3", ALU_OPX_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 16); settle(16);
    issue("mul_rst", ALU_OPX_MUL, 16'h0100, 16'h0101, 16'h0000, 4'b0000, 0, 1'b0);
`else
    issue("mul1", ALU_OPX_MUL, 16'h0100, 16'h0101, 16'h0100, 4'b0100, 0); settle(0);
    issue("mul2", ALU_OPX_MUL, 16'h0003, 16'h0005, 16'h0003, 4'b0100, 0); settle(0);
    issue("mul3", ALU_OPX_MUL, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0100, 0); settle(0);
    issue("mul_rst", ALU_OPX_MUL, 16'h0100, 16'h0101, 16'h0100, 4'b0100, 0);
`endif
    // Reset is sampled on the edge that would perform iteration 7
    bus.ALU_START = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_r",     32'(bus.ALU_R),     32'd0);
    check("abort_flags", 32'(bus.ALU_FLAGS), 32'd0);
    check("abort_busy",  32'(bus.ALU_BUSY),  32'd0);
    check("abort_done",  32'(bus.ALU_DONE),  32'd0);
    RESET = 1'b0;
    repeat (20) @(posedge CLK);
    #1;

    issue("add_post", ALU_OPX_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 0); settle(0);

    issue("b2b_add", ALU_OPX_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0);
    issue("b2b_and", ALU_OPX_AND, 16'h8000, 16'hFFFF, 16'h8000, 4'b0100, 0);
    settle(0);

    repeat (5) @(posedge CLK);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
